// File: rtl/tick_timer.sv
// ----------------------------------------------------------------------------
// tick_timer
//
// Counts data-level ticks coming from the divide-by-N clock-enable stage
// against a programmable period. Each elapsed period produces a one-clk
// expire pulse. The timer runs periodically or as a one-shot. Everything is
// in the clk domain: tick_in is sampled as data and never used as a clock.
//
// Optional feature macro: TICK_TIMER_EXPCNT_EN
//   defined   -> expire_count is a saturating count of expire pulses,
//                cleared only by reset
//   undefined -> expire_count is tied to 0
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   tick_in      in   divider output; each rising level seen on clk = 1 tick
//   load_valid   in   period load request
//   load_value   in   new period in ticks (0 is stored as 1)
//   load_ready   out  high whenever the timer is not in RUN
//   mode         in   0 = periodic, 1 = one-shot (captured at start)
//   start        in   start request
//   stop         in   abort request (wins over start and over a tick)
//   busy         out  high in RUN
//   done         out  high in DONE (one-shot completed)
//   expire       out  one-clk pulse per elapsed period (registered)
//   count        out  remaining ticks before expire, 0-based
//   expire_count out  saturating expire pulse count (optional feature)
//   state_dbg    out  current FSM state encoding, for observation
// ----------------------------------------------------------------------------
module tick_timer #(
   parameter int W        = 8,
   parameter int EXPCNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick_in,
   input  logic                load_valid,
   input  logic [W-1:0]        load_value,
   output logic                load_ready,
   input  logic                mode,
   input  logic                start,
   input  logic                stop,
   output logic                busy,
   output logic                done,
   output logic                expire,
   output logic [W-1:0]        count,
   output logic [EXPCNT_W-1:0] expire_count,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] ONE = W'(1);

   state_t         state_q,  state_d;
   logic [W-1:0]   period_q, period_d;
   logic [W-1:0]   count_q,  count_d;
   logic           mode_q,   mode_d;
   logic           expire_q, expire_d;
   logic           tick_q;
   logic           tick_edge;
   logic           load_acc;
   logic [W-1:0]   load_period;

   // A level held high on tick_in is one tick; tick_q clears on reset so a
   // high level right after reset release also counts as an edge.
   assign tick_edge = tick_in & ~tick_q;

   // Load handshake: a period load transfers in any cycle where load_valid
   // and load_ready are both high. load_ready depends only on state (never
   // on load_valid), so the upstream may hold load_valid until it sees ready.
   assign load_ready  = (state_q != ST_RUN);
   assign load_acc    = load_valid & load_ready;
   assign load_period = (load_value == '0) ? ONE : load_value;

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      count_d  = count_q;
      mode_d   = mode_q;
      expire_d = 1'b0;

      if (load_acc) begin
         period_d = load_period;
      end

      case (state_q)
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (tick_edge) begin
               if (count_q != '0) begin
                  count_d = count_q - ONE;
               end else begin
                  expire_d = 1'b1;
                  if (mode_q) begin
                     state_d = ST_DONE;
                     count_d = '0;
                  end else begin
                     count_d = period_q - ONE;
                  end
               end
            end
         end
         default: begin
            // IDLE and DONE share start/stop handling. period_d already
            // holds a same-cycle accepted load, so start uses the new period.
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (start) begin
               state_d = ST_RUN;
               count_d = period_d - ONE;
               mode_d  = mode;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         period_q <= ONE;
         count_q  <= '0;
         mode_q   <= 1'b0;
         expire_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         count_q  <= count_d;
         mode_q   <= mode_d;
         expire_q <= expire_d;
         tick_q   <= tick_in;
      end
   end

`ifdef TICK_TIMER_EXPCNT_EN
   logic [EXPCNT_W-1:0] expcnt_q, expcnt_d;

   always_comb begin
      expcnt_d = expcnt_q;
      if (expire_q && (expcnt_q != '1)) begin
         expcnt_d = expcnt_q + EXPCNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         expcnt_q <= '0;
      end else begin
         expcnt_q <= expcnt_d;
      end
   end

   assign expire_count = expcnt_q;
`else
   assign expire_count = '0;
`endif

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign expire    = expire_q;
   assign count     = count_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_tick_timer.sv
// ----------------------------------------------------------------------------
// tb_tick_timer
//
// Drives tick_timer with directed scenarios followed by random stimulus and
// compares every output against a tick-counting reference model. The model
// tracks the number of ticks seen since start and derives remaining count
// and expire timing from modular arithmetic on that number.
// ----------------------------------------------------------------------------
module tb_tick_timer;

   localparam int W        = 8;
   localparam int EXPCNT_W = 2;
   localparam int EXP_MAX  = (1 << EXPCNT_W) - 1;
`ifdef TICK_TIMER_EXPCNT_EN
   localparam bit EXPCNT_ON = 1'b1;
`else
   localparam bit EXPCNT_ON = 1'b0;
`endif

   // ---------------------------------------------------------------- clock/reset
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic                tick_in    = 1'b0;
   logic                load_valid = 1'b0;
   logic [W-1:0]        load_value = '0;
   logic                mode       = 1'b0;
   logic                start      = 1'b0;
   logic                stop       = 1'b0;
   logic                load_ready;
   logic                busy;
   logic                done;
   logic                expire;
   logic [W-1:0]        count;
   logic [EXPCNT_W-1:0] expire_count;
   logic [1:0]          state_dbg;

   tick_timer #(.W(W), .EXPCNT_W(EXPCNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .tick_in      (tick_in),
      .load_valid   (load_valid),
      .load_value   (load_value),
      .load_ready   (load_ready),
      .mode         (mode),
      .start        (start),
      .stop         (stop),
      .busy         (busy),
      .done         (done),
      .expire       (expire),
      .count        (count),
      .expire_count (expire_count),
      .state_dbg    (state_dbg)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_vec = 0;
   int n_err = 0;
   logic [0:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   bit m_run, m_done, m_mode, m_tick_prev, m_exp_prev;
   int m_period, m_n, m_expcnt;
   int div_ph = 0;

   task automatic model_reset();
      m_run = 0; m_done = 0; m_mode = 0; m_tick_prev = 0; m_exp_prev = 0;
      m_period = 1; m_n = 0; m_expcnt = 0;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_busy"},   busy, 0);
      check({pfx, "_done"},   done, 0);
      check({pfx, "_expire"}, expire, 0);
      check({pfx, "_count"},  count, 0);
      check({pfx, "_ready"},  load_ready, 1);
      check({pfx, "_expcnt"}, expire_count, 0);
   endtask

   // One clock: advance the model with the inputs currently applied, clock
   // the DUT, then compare all outputs 1 time unit after the edge.
   task automatic step();
      bit edge_v, acc, exp_next;
      int newp;
      check("load_ready", load_ready, !m_run);
      edge_v      = tick_in && !m_tick_prev;
      m_tick_prev = tick_in;
      acc         = load_valid && !m_run;
      newp        = acc ? ((load_value == 0) ? 1 : int'(load_value)) : m_period;
      exp_next    = 0;
      if (m_exp_prev && m_expcnt < EXP_MAX) m_expcnt++;
      if (m_run) begin
         if (stop) begin
            m_run = 0;
         end else if (edge_v) begin
            m_n++;
            if (m_n % m_period == 0) begin
               exp_next = 1;
               if (m_mode) begin
                  m_run  = 0;
                  m_done = 1;
               end
            end
         end
      end else if (stop) begin
         m_done = 0;
      end else if (start) begin
         m_run  = 1;
         m_done = 0;
         m_n    = 0;
         m_mode = mode;
      end
      m_period   = newp;
      m_exp_prev = exp_next;
      exp_q.push_back(exp_next);
      @(posedge clk);
      #1;
      check("expire", expire, exp_q.pop_front());
      check("busy", busy, m_run);
      check("done", done, m_done);
      check("count", count, m_run ? (m_period - 1 - (m_n % m_period)) : 0);
      check("expire_count", expire_count, EXPCNT_ON ? m_expcnt : 0);
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic drive_div();
      tick_in = (div_ph == 0);
      div_ph  = (div_ph + 1) % 3;
   endtask

   task automatic div_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive_div();
         step();
      end
   endtask

   task automatic do_load(input int v);
      load_valid = 1; load_value = W'(v);
      step();
      load_valid = 0;
   endtask

   task automatic do_start(input bit md);
      start = 1; mode = md;
      step();
      start = 0;
   endtask

   task automatic do_stop();
      stop = 1;
      step();
      stop = 0;
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      bit hit;
      model_reset();
      #2 reset = 1;
      // Reset held while tick_in toggles.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         tick_in = ~tick_in;
         check_reset_outputs("rst");
      end
      reset = 0;
      model_reset();
      div_cycles(20);

      // Periodic, period 3, divider pattern 1-high/2-low.
      tick_in = 0; div_ph = 1;
      do_load(3);
      do_start(0);
      div_cycles(36);
      do_stop();

      // One-shot, period 2, then extra ticks with no expire.
      do_load(2);
      do_start(1);
      div_cycles(15);
      // start + stop in DONE: stop wins.
      start = 1; stop = 1; step(); start = 0; stop = 0;

      // Stop coinciding with the terminal tick edge.
      do_load(2);
      do_start(0);
      hit = 0;
      for (int i = 0; i < 30; i++) begin
         drive_div();
         if (m_run && tick_in && !m_tick_prev && ((m_n + 1) % m_period == 0)) begin
            stop = 1; step(); stop = 0;
            hit = 1;
            break;
         end
         step();
      end
      check("stop_on_terminal_hit", hit, 1);
      div_cycles(4);

      // Load 0 -> period 1, expire on every tick; loads refused in RUN.
      do_load(0);
      do_start(0);
      div_cycles(9);
      load_valid = 1; load_value = 7;
      div_cycles(6);
      load_valid = 0;
      div_cycles(6);
      // start while in RUN is ignored.
      start = 1; drive_div(); step(); start = 0;
      div_cycles(3);
      do_stop();

      // Load 5 and start in the same cycle.
      load_valid = 1; load_value = 5; start = 1; mode = 0;
      drive_div(); step();
      load_valid = 0; start = 0;
      div_cycles(33);

      // Asynchronous reset in the middle of RUN.
      #3 reset = 1;
      #1 check_reset_outputs("midrst");
      model_reset();
      @(posedge clk); #1;
      reset = 0;
      div_cycles(6);

      // Random stimulus.
      for (int i = 0; i < 600; i++) begin
         tick_in    = $urandom_range(0, 1);
         start      = ($urandom_range(0, 11) == 0);
         stop       = ($urandom_range(0, 39) == 0);
         mode       = $urandom_range(0, 1);
         load_valid = ($urandom_range(0, 7) == 0);
         load_value = W'($urandom_range(0, 6));
         step();
      end
      start = 0; stop = 0; load_valid = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
